mem_bus_bridge: RTL and testbench

//  Responder side of the core FSM memory handshake (en_mem/W_R_mem/wordsize_mem/sign_mem -> done_mem/busy_mem/aligned_mem).

---
 rtl/mem_bus_bridge.sv | 246 ++++++++++++++++++++++++
 tb/tb_mem_bus_bridge.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_bridge
//  Purpose  : Responder for the core FSM memory handshake. Each accepted
//             request becomes a single transfer on a valid/ready memory bus.
//             The bridge generates byte strobes, replicates store data,
//             extracts and sign/zero-extends load data, and bounds each bus
//             wait with an optional timeout.
//  Ports    : clk, reset (sync, active-low)
//             Core side : en_mem, W_R_mem[1:0], wordsize_mem[1:0], sign_mem,
//                         addr_mem[31:0], wdata_mem[31:0] -> rdata_mem[31:0],
//                         done_mem, busy_mem, aligned_mem, err_timeout
//             Bus side  : mem_valid, mem_instr, mem_addr[31:0],
//                         mem_wdata[31:0], mem_wstrb[3:0] <- mem_rdata[31:0],
//                         mem_ready
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus_bridge #(
   parameter int TIMEOUT = 256   // max BUS cycles waiting for mem_ready; 0 = none
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en_mem,
   input  logic [1:0]  W_R_mem,
   input  logic [1:0]  wordsize_mem,
   input  logic        sign_mem,
   input  logic [31:0] addr_mem,
   input  logic [31:0] wdata_mem,
   output logic [31:0] rdata_mem,
   output logic        done_mem,
   output logic        busy_mem,
   output logic        aligned_mem,
   output logic        err_timeout,
   output logic        mem_valid,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_BUS      = 2'd1;
   localparam logic [1:0] ST_DONE     = 2'd2;
   localparam logic [1:0] ST_MISALIGN = 2'd3;

   localparam logic [1:0] WR_STORE = 2'b00;
   localparam logic [1:0] WR_RSVD  = 2'b10;
   localparam logic [1:0] WR_FETCH = 2'b11;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Counter is sized to hold TIMEOUT-1, the value seen in the last allowed
   // BUS cycle.
   localparam int             CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int             C_LAST = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
   localparam logic [CW-1:0]  C_TMAX = C_LAST[CW-1:0];

   logic [1:0]    state_q,   state_d;
   logic [1:0]    wr_q,      wr_d;
   logic [1:0]    size_q,    size_d;
   logic          sign_q,    sign_d;
   logic [1:0]    lane_q,    lane_d;
   logic [CW-1:0] cnt_q,     cnt_d;
   logic [31:0]   rdata_q,   rdata_d;
   logic          aligned_q, aligned_d;
   logic          err_q,     err_d;
   logic          valid_q,   valid_d;
   logic          instr_q,   instr_d;
   logic [31:0]   addr_q,    addr_d;
   logic [31:0]   wdata_q,   wdata_d;
   logic [3:0]    wstrb_q,   wstrb_d;

   logic          illegal;
   logic          expire;
   logic [31:0]   rd_shift;
   logic [31:0]   load_val;
   logic [3:0]    strb_req;
   logic [31:0]   wdata_req;

   // Request legality; a fetch is always a word, whatever size is presented.
   always_comb begin
      illegal = 1'b0;
      if (wordsize_mem == 2'b11)
         illegal = 1'b1;
      else if (W_R_mem == WR_FETCH)
         illegal = (addr_mem[1:0] != 2'b00);
      else if (wordsize_mem == SZ_HALF)
         illegal = addr_mem[0];
      else if (wordsize_mem == SZ_WORD)
         illegal = (addr_mem[1:0] != 2'b00);
   end

   // Store lane strobes and replicated data for the incoming request.
   always_comb begin
      strb_req  = 4'b0000;
      wdata_req = wdata_mem;
      if (W_R_mem == WR_STORE) begin
         case (wordsize_mem)
            SZ_BYTE: begin
               strb_req  = 4'b0001 << addr_mem[1:0];
               wdata_req = {4{wdata_mem[7:0]}};
            end
            SZ_HALF: begin
               strb_req  = 4'b0011 << addr_mem[1:0];
               wdata_req = {2{wdata_mem[15:0]}};
            end
            default: begin
               strb_req  = 4'b1111;
               wdata_req = wdata_mem;
            end
         endcase
      end
   end

   // Load extraction: shift the addressed lane down to bit 0, then extend.
   always_comb begin
      rd_shift = mem_rdata >> {lane_q, 3'b000};
      load_val = mem_rdata;
      if (wr_q != WR_FETCH) begin
         case (size_q)
            SZ_BYTE: load_val = {{24{sign_q & rd_shift[7]}},  rd_shift[7:0]};
            SZ_HALF: load_val = {{16{sign_q & rd_shift[15]}}, rd_shift[15:0]};
            default: load_val = mem_rdata;
         endcase
      end
   end

   assign expire = (TIMEOUT != 0) && (cnt_q == C_TMAX);

   always_comb begin
      state_d   = state_q;
      wr_d      = wr_q;
      size_d    = size_q;
      sign_d    = sign_q;
      lane_d    = lane_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      aligned_d = aligned_q;
      err_d     = err_q;
      valid_d   = valid_q;
      instr_d   = instr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;

      case (state_q)
         ST_IDLE: begin
            if (en_mem) begin
               wr_d   = W_R_mem;
               size_d = wordsize_mem;
               sign_d = sign_mem;
               lane_d = addr_mem[1:0];
               if (illegal) begin
                  state_d   = ST_MISALIGN;
                  aligned_d = 1'b0;
               end else if (W_R_mem == WR_RSVD) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_BUS;
                  valid_d = 1'b1;
                  instr_d = (W_R_mem == WR_FETCH);
                  addr_d  = {addr_mem[31:2], 2'b00};
                  wdata_d = wdata_req;
                  wstrb_d = strb_req;
                  cnt_d   = '0;
               end
            end
         end
         ST_BUS: begin
            cnt_d = cnt_q + 1'b1;
            // mem_ready has priority over a timeout expiring in the same cycle.
            if (mem_ready) begin
               state_d = ST_DONE;
               valid_d = 1'b0;
               if (wr_q != WR_STORE)
                  rdata_d = load_val;
            end else if (expire) begin
               state_d = ST_DONE;
               valid_d = 1'b0;
               err_d   = 1'b1;
               rdata_d = 32'h0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         ST_MISALIGN: begin
            state_d = ST_MISALIGN;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         wr_q      <= 2'b00;
         size_q    <= 2'b00;
         sign_q    <= 1'b0;
         lane_q    <= 2'b00;
         cnt_q     <= '0;
         rdata_q   <= 32'h0;
         aligned_q <= 1'b1;
         err_q     <= 1'b0;
         valid_q   <= 1'b0;
         instr_q   <= 1'b0;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         wstrb_q   <= 4'b0000;
      end else begin
         state_q   <= state_d;
         wr_q      <= wr_d;
         size_q    <= size_d;
         sign_q    <= sign_d;
         lane_q    <= lane_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
         aligned_q <= aligned_d;
         err_q     <= err_d;
         valid_q   <= valid_d;
         instr_q   <= instr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
      end
   end

   assign rdata_mem   = rdata_q;
   assign done_mem    = (state_q == ST_DONE);
   assign busy_mem    = (state_q == ST_BUS) || (state_q == ST_DONE);
   assign aligned_mem = aligned_q;
   assign err_timeout = err_q;
   assign mem_valid   = valid_q;
   assign mem_instr   = instr_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign mem_wstrb   = wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_bridge
//  Purpose  : Directed self-checking bench for mem_bus_bridge (TIMEOUT=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_bridge;

   logic        clk;
   logic        reset;
   logic        en_mem;
   logic [1:0]  W_R_mem;
   logic [1:0]  wordsize_mem;
   logic        sign_mem;
   logic [31:0] addr_mem;
   logic [31:0] wdata_mem;
   logic [31:0] rdata_mem;
   logic        done_mem;
   logic        busy_mem;
   logic        aligned_mem;
   logic        err_timeout;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   int total;
   int passed;

   mem_bus_bridge #(.TIMEOUT(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .en_mem       (en_mem),
      .W_R_mem      (W_R_mem),
      .wordsize_mem (wordsize_mem),
      .sign_mem     (sign_mem),
      .addr_mem     (addr_mem),
      .wdata_mem    (wdata_mem),
      .rdata_mem    (rdata_mem),
      .done_mem     (done_mem),
      .busy_mem     (busy_mem),
      .aligned_mem  (aligned_mem),
      .err_timeout  (err_timeout),
      .mem_valid    (mem_valid),
      .mem_instr    (mem_instr),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_wstrb    (mem_wstrb),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic request(input logic [1:0] wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
      en_mem       = 1'b1;
      W_R_mem      = wr;
      wordsize_mem = sz;
      sign_mem     = sg;
      addr_mem     = a;
      wdata_mem    = wd;
      tick();
      en_mem       = 1'b0;
   endtask

   // Single-cycle load: request, ready in the first BUS cycle, check result.
   task automatic quick_load(input string tag, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] rd,
                             input logic [31:0] exp);
      request(2'b01, sz, sg, a, 32'h0);
      mem_ready = 1'b1;
      mem_rdata = rd;
      tick();
      mem_ready = 1'b0;
      chk({tag, "_done"}, {31'b0, done_mem}, 32'd1);
      chk({tag, "_rdata"}, rdata_mem, exp);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total        = 0;
      passed       = 0;
      reset        = 1'b0;
      en_mem       = 1'b0;
      W_R_mem      = 2'b00;
      wordsize_mem = 2'b00;
      sign_mem     = 1'b0;
      addr_mem     = 32'h0;
      wdata_mem    = 32'h0;
      mem_rdata    = 32'h0;
      mem_ready    = 1'b0;

      // ---- reset state
      tick();
      tick();
      chk("rst_done",    {31'b0, done_mem},    32'd0);
      chk("rst_busy",    {31'b0, busy_mem},    32'd0);
      chk("rst_aligned", {31'b0, aligned_mem}, 32'd1);
      chk("rst_err",     {31'b0, err_timeout}, 32'd0);
      chk("rst_valid",   {31'b0, mem_valid},   32'd0);
      chk("rst_wstrb",   {28'b0, mem_wstrb},   32'd0);
      chk("rst_addr",    mem_addr,             32'h0);
      chk("rst_rdata",   rdata_mem,            32'h0);
      reset = 1'b1;
      tick();

      // ---- word fetch, ready in the third BUS cycle
      request(2'b11, 2'b10, 1'b0, 32'h100, 32'h0);
      chk("fetch_valid", {31'b0, mem_valid}, 32'd1);
      chk("fetch_instr", {31'b0, mem_instr}, 32'd1);
      chk("fetch_wstrb", {28'b0, mem_wstrb}, 32'd0);
      chk("fetch_addr",  mem_addr,           32'h100);
      chk("fetch_busy",  {31'b0, busy_mem},  32'd1);
      tick();
      tick();
      mem_ready = 1'b1;
      mem_rdata = 32'h0000_0013;
      tick();
      mem_ready = 1'b0;
      chk("fetch_done",    {31'b0, done_mem},  32'd1);
      chk("fetch_rdata",   rdata_mem,          32'h13);
      chk("fetch_vdrop",   {31'b0, mem_valid}, 32'd0);
      tick();
      chk("fetch_done1",   {31'b0, done_mem},  32'd0);
      chk("fetch_idle",    {31'b0, busy_mem},  32'd0);
      chk("fetch_hold",    rdata_mem,          32'h13);

      // ---- load lane extraction
      quick_load("lb_s3", 2'b00, 1'b1, 32'h203, 32'h80FF_0000, 32'hFFFF_FF80);
      quick_load("lb_u3", 2'b00, 1'b0, 32'h203, 32'h80FF_0000, 32'h0000_0080);
      quick_load("lb_s1", 2'b00, 1'b1, 32'h201, 32'h1234_ABCD, 32'hFFFF_FFAB);
      quick_load("lh_s2", 2'b01, 1'b1, 32'h202, 32'h80FF_0000, 32'hFFFF_80FF);
      quick_load("lh_u0", 2'b01, 1'b0, 32'h200, 32'h1234_ABCD, 32'h0000_ABCD);
      quick_load("lw",    2'b10, 1'b1, 32'h204, 32'h8765_4321, 32'h8765_4321);

      // ---- half store
      request(2'b00, 2'b01, 1'b0, 32'h12, 32'h0000_BEEF);
      chk("sh_addr",  mem_addr,           32'h10);
      chk("sh_wstrb", {28'b0, mem_wstrb}, 32'hC);
      chk("sh_wdata", mem_wdata,          32'hBEEF_BEEF);
      chk("sh_instr", {31'b0, mem_instr}, 32'd0);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("sh_done",  {31'b0, done_mem},  32'd1);
      chk("sh_rdata", rdata_mem,          32'h8765_4321);
      tick();

      // ---- byte store
      request(2'b00, 2'b00, 1'b0, 32'h1, 32'hFFFF_FFA5);
      chk("sb_wstrb", {28'b0, mem_wstrb}, 32'h2);
      chk("sb_wdata", mem_wdata,          32'hA5A5_A5A5);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();

      // ---- word store, with a stray en_mem during BUS that must be ignored
      request(2'b00, 2'b10, 1'b0, 32'h4, 32'hDEAD_BEEF);
      chk("sw_wstrb", {28'b0, mem_wstrb}, 32'hF);
      chk("sw_wdata", mem_wdata,          32'hDEAD_BEEF);
      en_mem   = 1'b1;
      W_R_mem  = 2'b01;
      addr_mem = 32'h8;
      tick();
      en_mem   = 1'b0;
      chk("ign_addr",  mem_addr,           32'h4);
      chk("ign_valid", {31'b0, mem_valid}, 32'd1);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("sw_done", {31'b0, done_mem}, 32'd1);
      tick();
      chk("sw_idle", {31'b0, busy_mem}, 32'd0);

      // ---- reserved W_R: straight to DONE, no bus
      request(2'b10, 2'b10, 1'b0, 32'h0, 32'h0);
      chk("rsv_done",  {31'b0, done_mem},  32'd1);
      chk("rsv_valid", {31'b0, mem_valid}, 32'd0);
      chk("rsv_rdata", rdata_mem,          32'h8765_4321);
      tick();

      // ---- ready arriving in the same cycle the timeout expires
      request(2'b01, 2'b10, 1'b0, 32'h44, 32'h0);
      tick();
      tick();
      tick();
      mem_ready = 1'b1;
      mem_rdata = 32'h55AA_55AA;
      tick();
      mem_ready = 1'b0;
      chk("race_done",  {31'b0, done_mem},    32'd1);
      chk("race_err",   {31'b0, err_timeout}, 32'd0);
      chk("race_rdata", rdata_mem,            32'h55AA_55AA);
      tick();

      // ---- timeout: valid for exactly 4 cycles
      request(2'b01, 2'b10, 1'b0, 32'h40, 32'h0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("to_valid%0d", i), {31'b0, mem_valid}, 32'd1);
         tick();
      end
      chk("to_vdrop", {31'b0, mem_valid},   32'd0);
      chk("to_err",   {31'b0, err_timeout}, 32'd1);
      chk("to_done",  {31'b0, done_mem},    32'd1);
      chk("to_rdata", rdata_mem,            32'h0);
      tick();
      chk("to_sticky", {31'b0, err_timeout}, 32'd1);

      // ---- reset in BUS, late ready, then back-to-back requests
      request(2'b11, 2'b10, 1'b0, 32'h0, 32'h0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("mr_valid",   {31'b0, mem_valid},   32'd0);
      chk("mr_busy",    {31'b0, busy_mem},    32'd0);
      chk("mr_aligned", {31'b0, aligned_mem}, 32'd1);
      chk("mr_err",     {31'b0, err_timeout}, 32'd0);
      mem_ready = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      tick();
      mem_ready = 1'b0;
      chk("late_done",  {31'b0, done_mem}, 32'd0);
      chk("late_rdata", rdata_mem,         32'h0);
      request(2'b01, 2'b10, 1'b0, 32'h8, 32'h0);
      mem_ready = 1'b1;
      mem_rdata = 32'h1122_3344;
      tick();
      mem_ready = 1'b0;
      chk("b2b1_rdata", rdata_mem, 32'h1122_3344);
      tick();
      request(2'b01, 2'b00, 1'b0, 32'hC, 32'h0);
      chk("b2b2_valid", {31'b0, mem_valid}, 32'd1);
      mem_ready = 1'b1;
      mem_rdata = 32'h0000_00F0;
      tick();
      mem_ready = 1'b0;
      chk("b2b2_rdata", rdata_mem, 32'h0000_00F0);
      tick();

      // ---- misaligned word load: terminal
      request(2'b01, 2'b10, 1'b0, 32'h6, 32'h0);
      chk("mis_aligned", {31'b0, aligned_mem}, 32'd0);
      chk("mis_valid",   {31'b0, mem_valid},   32'd0);
      chk("mis_done",    {31'b0, done_mem},    32'd0);
      chk("mis_busy",    {31'b0, busy_mem},    32'd0);
      request(2'b01, 2'b10, 1'b0, 32'h8, 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("mis_trap_v%0d", i), {30'b0, mem_valid, done_mem}, 32'd0);
         chk($sformatf("mis_trap_a%0d", i), {31'b0, aligned_mem}, 32'd0);
         tick();
      end

      // ---- illegal size after a fresh reset
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("rst2_aligned", {31'b0, aligned_mem}, 32'd1);
      request(2'b01, 2'b11, 1'b0, 32'h0, 32'h0);
      chk("ill_aligned", {31'b0, aligned_mem}, 32'd0);
      chk("ill_valid",   {31'b0, mem_valid},   32'd0);
      reset = 1'b0;
      tick();
      reset = 1'b1;

      // ---- misaligned fetch after reset
      request(2'b11, 2'b00, 1'b0, 32'h102, 32'h0);
      chk("misf_aligned", {31'b0, aligned_mem}, 32'd0);
      chk("misf_valid",   {31'b0, mem_valid},   32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
